spike_rate_monitor: RTL and testbench
=====================================

Name: spike_rate_monitor

Overview:
- Downstream consumer of the spiking neuron's 1-bit spike output.
- Counts spike rising edges over a programmable window of clock cycles and latches the per-window rate.
- Flags saturation and drives a single 7-segment digit for the board display.
- Sits between spiking_neuron.spike and the top-level display outputs.

Parameters:
- WIN_W, 16, width of window length and window cycle counter.
- CNT_W, 8, width of spike accumulator and rate_out.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- spike_in  input  1  spike level from the neuron, synchronous to clk
- count_en  input  1  1 = measure; 0 = idle, accumulators cleared
- window_len  input  WIN_W  window length in cycles; 0 = idle
- rate_out  output  CNT_W  spike edges counted in the last completed window
- rate_valid  output  1  one-cycle pulse when rate_out updates
- overflow  output  1  last completed window saturated the accumulator
- seg_out  output  7  active-high segments, bit0=a … bit6=g, showing min(rate_out,15) in hex

Behaviour:
- Reset (synchronous, active-high, dominates everything):
  - rate_out=0, rate_valid=0, overflow=0, seg_out=7'b0111111 ("0").
  - Internal: spike_prev=0, acc=0, win_cnt=0, sat=0, win_lat=0, state=IDLE.
- Edge detect:
  - edge = spike_in & ~spike_prev.
  - spike_prev registered every cycle in all states.
  - A spike held high counts once; back-to-back pulses 1,0,1 count twice.
- FSM states: IDLE, COUNT.
  - IDLE -> COUNT when count_en=1 and window_len!=0. That cycle latches win_lat=window_len, sets win_cnt=0, acc=0, sat=0. Edges in this cycle are not counted.
  - COUNT -> IDLE when count_en=0 or reset. The partial window is discarded and rate_out, overflow and seg_out hold their last values.
- Window counting (COUNT):
  - Each cycle: if edge, acc=acc+1, saturating at 2^CNT_W-1. Set sat=1 when an edge arrives with acc already at max.
  - Terminal cycle is win_cnt==win_lat-1. That cycle's edge counts toward the closing window.
  - At the terminal edge of clk: rate_out=final count, overflow=sat (final), rate_valid=1 for exactly one cycle.
  - Same edge: win_cnt=0, acc=0, sat=0, win_lat re-sampled from window_len. If window_len==0 at this point, go to IDLE.
  - Otherwise win_cnt increments.
- Timing and window semantics:
  - win_lat=1 gives one window per cycle, so rate_valid stays high continuously. rate_out then equals that cycle's edge (0/1).
  - Changes to window_len mid-window take effect at the next window boundary only.
  - Latency: rate_out/rate_valid are registered and appear the cycle after the terminal cycle.
- seg_out:
  - Registered, updated on the same edge as rate_out.
  - Decodes min(rate_out,15) to hex 0-F. Values ≥15 display "F".
  - Hex patterns (g..a):
    - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111
    - 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001
- Simultaneous events:
  - reset beats count_en.
  - count_en falling on the terminal cycle: the window is discarded and no rate_valid is issued.

Test Plan:
- Reset check: reset high 2 cycles with spike_in toggling -> rate_out=0, rate_valid=0, overflow=0, seg_out=0111111 throughout.
- Basic window: window_len=10, count_en=1, 3 single-cycle spikes inside the window -> one rate_valid pulse 11 cycles after enable, rate_out=3, seg_out=1001111.
- Level spike: spike_in held high 6 cycles inside a 10-cycle window -> rate_out=1. Alternating 1/0 for 8 cycles -> rate_out=4.
- Saturation: CNT_W=8, window_len=1000, spike toggling every 2 cycles -> rate_out=255, overflow=1, seg_out=1110001. Next window with 2 spikes -> rate_out=2, overflow=0.
- Abort: count_en dropped on cycle 5 of a 10-cycle window with 2 spikes -> no rate_valid, previous rate_out held. Re-enable -> fresh window, first pulse 11 cycles later.
- Window change: window_len switched 10->4 mid-window -> current window closes at 10, subsequent rate_valid pulses every 4 cycles. window_len=0 at a boundary -> block goes to IDLE, no further pulses.

Source files
------------

// File: rtl/spike_rate_monitor.sv
// spike_rate_monitor: counts spike rising edges over a programmable window of
// clock cycles, latches the per-window rate, flags accumulator saturation and
// drives a single hex 7-segment digit showing min(rate, 15).
module spike_rate_monitor #(
  parameter int unsigned WIN_W = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             spike_in,
  input  logic             count_en,
  input  logic [WIN_W-1:0] window_len,
  output logic [CNT_W-1:0] rate_out,
  output logic             rate_valid,
  output logic             overflow,
  output logic [6:0]       seg_out
);

  localparam logic [CNT_W-1:0] ACC_MAX  = '1;
  localparam logic [6:0]       SEG_ZERO = 7'b0111111;

  typedef enum logic {IDLE, COUNT} state_t;

  state_t           state_q, state_d;
  logic             spike_prev_q;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic             sat_q, sat_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [WIN_W-1:0] win_lat_q, win_lat_d;
  logic [CNT_W-1:0] rate_q, rate_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic [6:0]       seg_q, seg_d;

  logic             edge_c;
  logic             term_c;
  logic [CNT_W-1:0] acc_inc_c;
  logic             sat_inc_c;
  logic [3:0]       disp_c;

  // Hex digit to active-high segments {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b0111111;
      4'h1: s = 7'b0000110;
      4'h2: s = 7'b1011011;
      4'h3: s = 7'b1001111;
      4'h4: s = 7'b1100110;
      4'h5: s = 7'b1101101;
      4'h6: s = 7'b1111101;
      4'h7: s = 7'b0000111;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1101111;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b1111100;
      4'hC: s = 7'b0111001;
      4'hD: s = 7'b1011110;
      4'hE: s = 7'b1111001;
      default: s = 7'b1110001;
    endcase
    return s;
  endfunction

  // Rising-edge detect, saturating accumulate, terminal-cycle detect, display clamp
  assign edge_c    = spike_in & ~spike_prev_q;
  assign term_c    = (win_cnt_q == (win_lat_q - WIN_W'(1)));
  assign acc_inc_c = (edge_c && (acc_q != ACC_MAX)) ? (acc_q + CNT_W'(1)) : acc_q;
  assign sat_inc_c = sat_q | (edge_c & (acc_q == ACC_MAX));
  assign disp_c    = (acc_inc_c > CNT_W'(15)) ? 4'hF : acc_inc_c[3:0];

  // Next-state and window bookkeeping
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    sat_d     = sat_q;
    win_cnt_d = win_cnt_q;
    win_lat_d = win_lat_q;
    rate_d    = rate_q;
    ovf_d     = ovf_q;
    seg_d     = seg_q;
    valid_d   = 1'b0;
    case (state_q)
      IDLE: begin
        acc_d     = '0;
        sat_d     = 1'b0;
        win_cnt_d = '0;
        if (count_en && (window_len != '0)) begin
          state_d   = COUNT;
          win_lat_d = window_len;
        end
      end
      COUNT: begin
        if (!count_en) begin
          // Partial window discarded; displayed results hold
          state_d   = IDLE;
          acc_d     = '0;
          sat_d     = 1'b0;
          win_cnt_d = '0;
        end else if (term_c) begin
          valid_d   = 1'b1;
          rate_d    = acc_inc_c;
          ovf_d     = sat_inc_c;
          seg_d     = seg_decode(disp_c);
          acc_d     = '0;
          sat_d     = 1'b0;
          win_cnt_d = '0;
          win_lat_d = window_len;
          if (window_len == '0) state_d = IDLE;
        end else begin
          acc_d     = acc_inc_c;
          sat_d     = sat_inc_c;
          win_cnt_d = win_cnt_q + WIN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      spike_prev_q <= 1'b0;
      acc_q        <= '0;
      sat_q        <= 1'b0;
      win_cnt_q    <= '0;
      win_lat_q    <= '0;
      rate_q       <= '0;
      valid_q      <= 1'b0;
      ovf_q        <= 1'b0;
      seg_q        <= SEG_ZERO;
    end else begin
      state_q      <= state_d;
      spike_prev_q <= spike_in;
      acc_q        <= acc_d;
      sat_q        <= sat_d;
      win_cnt_q    <= win_cnt_d;
      win_lat_q    <= win_lat_d;
      rate_q       <= rate_d;
      valid_q      <= valid_d;
      ovf_q        <= ovf_d;
      seg_q        <= seg_d;
    end
  end

  assign rate_out   = rate_q;
  assign rate_valid = valid_q;
  assign overflow   = ovf_q;
  assign seg_out    = seg_q;

endmodule

// File: tb/tb_spike_rate_monitor.sv
// Bench for spike_rate_monitor: directed scenarios plus randomized traffic,
// compared every cycle against a window-level reference model.
module tb_spike_rate_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic        spike_in;
  logic        count_en;
  logic [15:0] window_len;
  logic [7:0]  rate_out;
  logic        rate_valid;
  logic        overflow;
  logic [6:0]  seg_out;

  int checks   = 0;
  int failures = 0;

  // Reference model state: unsaturated edge total and elapsed cycles per window
  bit          m_active;
  bit          m_prev;
  int          m_len;
  int          m_elapsed;
  int          m_edges;
  int          exp_rate;
  bit          exp_valid;
  bit          exp_ovf;
  logic [6:0]  exp_seg;
  int          pulses;

  logic [6:0] seg_tab [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};

  spike_rate_monitor #(.WIN_W(16), .CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .spike_in   (spike_in),
    .count_en   (count_en),
    .window_len (window_len),
    .rate_out   (rate_out),
    .rate_valid (rate_valid),
    .overflow   (overflow),
    .seg_out    (seg_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs the DUT sampled
  task automatic model_step();
    bit e;
    int clamped;
    e = spike_in && !m_prev;
    exp_valid = 1'b0;
    if (reset) begin
      m_prev = 1'b0; m_active = 1'b0; m_edges = 0; m_elapsed = 0;
      exp_rate = 0; exp_ovf = 1'b0; exp_seg = seg_tab[0];
      return;
    end
    m_prev = spike_in;
    if (!m_active) begin
      if (count_en && window_len != 0) begin
        m_active = 1'b1; m_len = int'(window_len); m_elapsed = 0; m_edges = 0;
      end
    end else if (!count_en) begin
      m_active = 1'b0;
    end else begin
      m_edges += int'(e);
      m_elapsed++;
      if (m_elapsed == m_len) begin
        exp_valid = 1'b1;
        pulses++;
        exp_rate  = (m_edges > 255) ? 255 : m_edges;
        exp_ovf   = (m_edges > 255);
        clamped   = (exp_rate > 15) ? 15 : exp_rate;
        exp_seg   = seg_tab[clamped];
        m_len = int'(window_len); m_elapsed = 0; m_edges = 0;
        if (window_len == 0) m_active = 1'b0;
      end
    end
  endtask

  task automatic step(input bit rst, input bit en, input int len, input bit sp);
    reset = rst; count_en = en; window_len = 16'(len); spike_in = sp;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_eq("rate_out",   32'(rate_out),   32'(exp_rate));
    check_eq("rate_valid", 32'(rate_valid), 32'(exp_valid));
    check_eq("overflow",   32'(overflow),   32'(exp_ovf));
    check_eq("seg_out",    32'(seg_out),    32'(exp_seg));
  endtask

  int len_r;
  bit en_r;

  initial begin
    pulses = 0;
    m_prev = 1'b0; m_active = 1'b0;
    // Reset with toggling spike and enable asserted
    step(1, 1, 10, 1);
    step(1, 1, 10, 0);
    step(0, 0, 10, 0);
    step(0, 0, 10, 1);
    // Basic window with three single-cycle spikes
    for (int i = 0; i < 14; i++) step(0, 1, 10, (i == 2 || i == 5 || i == 8));
    // Level spike held for six cycles
    step(0, 0, 10, 0);
    for (int i = 0; i < 12; i++) step(0, 1, 10, (i >= 2 && i < 8));
    // Alternating pulses
    step(0, 0, 10, 0);
    for (int i = 0; i < 12; i++) step(0, 1, 10, (i >= 1 && i < 9) ? ((i % 2) == 1) : 1'b0);
    // Saturation, then a short window with two spikes
    step(0, 0, 1000, 0);
    for (int i = 0; i < 1001; i++) step(0, 1, (i > 900) ? 20 : 1000, (i % 2) == 1);
    for (int i = 0; i < 22; i++) step(0, 1, 20, (i == 3 || i == 9));
    // Abort mid-window, then re-enable
    step(0, 0, 10, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 10, (i == 1 || i == 3));
    for (int i = 0; i < 3; i++) step(0, 0, 10, 0);
    for (int i = 0; i < 13; i++) step(0, 1, 10, (i == 4));
    // Window length change mid-window, then zero at a boundary
    step(0, 0, 10, 0);
    for (int i = 0; i < 24; i++) step(0, 1, (i < 5) ? 10 : 4, (i % 3) == 0);
    for (int i = 0; i < 12; i++) step(0, 1, 0, (i % 2) == 0);
    // Single-cycle windows
    step(0, 0, 1, 0);
    for (int i = 0; i < 20; i++) step(0, 1, 1, 1'($urandom_range(0, 1)));
    // Randomized traffic
    len_r = 5; en_r = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) len_r = $urandom_range(0, 7);
      if ($urandom_range(0, 49) == 0) en_r = ~en_r;
      step($urandom_range(0, 299) == 0, en_r, len_r, $urandom_range(0, 2) == 0);
    end
    check_eq("pulses_seen", 32'(pulses > 100), 32'(1));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
